// File: rtl/clock_bcd_timekeeper_if.sv
// rtl/clock_bcd_timekeeper_if.sv - control inputs and BCD time outputs of the timekeeper
interface clock_bcd_timekeeper_if;
    logic       tick;
    logic       mode_btn;
    logic       inc_btn;
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
    logic [2:0] set_sel;
    logic       min_co;
    logic       hour_co;
    logic       day_co;

    modport master (
        output tick, mode_btn, inc_btn,
        input  hour, min, sec, set_sel, min_co, hour_co, day_co
    );

    modport slave (
        input  tick, mode_btn, inc_btn,
        output hour, min, sec, set_sel, min_co, hour_co, day_co
    );
endinterface

// File: rtl/clock_bcd_timekeeper.sv
// rtl/clock_bcd_timekeeper.sv - BCD hh:mm:ss timekeeper with RUN/SET_H/SET_M/SET_S adjust modes
module clock_bcd_timekeeper #(
    parameter logic [7:0] PRESET_H = 8'h00,
    parameter logic [7:0] PRESET_M = 8'h00,
    parameter logic [7:0] PRESET_S = 8'h00
) (
    input  logic                   CP,
    input  logic                   CR,
    clock_bcd_timekeeper_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_t;

    state_t     state;
    logic [7:0] hour_q;
    logic [7:0] min_q;
    logic [7:0] sec_q;
    logic       min_co_q;
    logic       hour_co_q;
    logic       day_co_q;

    logic run_tick;
    logic s_wrap;
    logic m_wrap;
    logic h_wrap;

    // Two-digit BCD increment that rolls over to 00 after reaching top.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        if (v == top)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign run_tick = (state == RUN) && bus.tick;
    assign s_wrap   = (sec_q == 8'h59);
    assign m_wrap   = (min_q == 8'h59);
    assign h_wrap   = (hour_q == 8'h23);

    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            state     <= RUN;
            hour_q    <= PRESET_H;
            min_q     <= PRESET_M;
            sec_q     <= PRESET_S;
            min_co_q  <= 1'b0;
            hour_co_q <= 1'b0;
            day_co_q  <= 1'b0;
        end else begin
            min_co_q  <= run_tick && s_wrap;
            hour_co_q <= run_tick && s_wrap && m_wrap;
            day_co_q  <= run_tick && s_wrap && m_wrap && h_wrap;

            // A tick in RUN is counted even when mode_btn leaves RUN on this same edge.
            if (run_tick) begin
                sec_q <= bcd_inc(sec_q, 8'h59);
                if (s_wrap)
                    min_q <= bcd_inc(min_q, 8'h59);
                if (s_wrap && m_wrap)
                    hour_q <= bcd_inc(hour_q, 8'h23);
            end

            if (bus.mode_btn) begin
                case (state)
                    RUN:     state <= SET_H;
                    SET_H:   state <= SET_M;
                    SET_M:   state <= SET_S;
                    default: state <= RUN;
                endcase
            end else if (bus.inc_btn) begin
                case (state)
                    SET_H:   hour_q <= bcd_inc(hour_q, 8'h23);
                    SET_M:   min_q  <= bcd_inc(min_q, 8'h59);
                    SET_S:   sec_q  <= bcd_inc(sec_q, 8'h59);
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        bus.set_sel = 3'b000;
        case (state)
            SET_H:   bus.set_sel = 3'b100;
            SET_M:   bus.set_sel = 3'b010;
            SET_S:   bus.set_sel = 3'b001;
            default: bus.set_sel = 3'b000;
        endcase
    end

    assign bus.hour    = hour_q;
    assign bus.min     = min_q;
    assign bus.sec     = sec_q;
    assign bus.min_co  = min_co_q;
    assign bus.hour_co = hour_co_q;
    assign bus.day_co  = day_co_q;

endmodule

// File: doc/clock_bcd_timekeeper.md
CLOCK_BCD_TIMEKEEPER -- requirements
Module: clock_bcd_timekeeper

Interface
REQ-001 Parameter PRESET_H, default 8'h00, BCD hour value loaded at reset (legal 00..23).
REQ-002 Parameter PRESET_M, default 8'h00, BCD minute value loaded at reset (legal 00..59).
REQ-003 Parameter PRESET_S, default 8'h00, BCD second value loaded at reset (legal 00..59).
REQ-004 CP  input  1  system clock; all state changes on the rising edge.
REQ-005 CR  input  1  reset, asynchronous, active-low.
REQ-006 tick  input  1  one-CP-cycle enable pulse at 1 Hz from the upstream prescaler.
REQ-007 mode_btn  input  1  one-cycle pulse, debounced upstream, that advances the operating mode.
REQ-008 inc_btn  input  1  one-cycle pulse, debounced upstream, that increments the selected field.
REQ-009 hour  output  8  BCD hours {tens[7:4], units[3:0]}, 00..23.
REQ-010 min  output  8  BCD minutes, 00..59.
REQ-011 sec  output  8  BCD seconds, 00..59.
REQ-012 set_sel  output  3  one-hot field under adjustment {H,M,S}; 000 in RUN.
REQ-013 min_co  output  1  one-cycle pulse on a tick-driven seconds wrap 59->00.
REQ-014 hour_co  output  1  one-cycle pulse on a tick-driven minutes wrap 59->00.
REQ-015 day_co  output  1  one-cycle pulse on a tick-driven 23:59:59->00:00:00.

Function
REQ-016 The FSM SHALL have states RUN, SET_H, SET_M and SET_S.
REQ-017 A mode_btn pulse SHALL move RUN->SET_H->SET_M->SET_S->RUN, one step per pulse.
REQ-018 set_sel SHALL be 100 in SET_H, 010 in SET_M, 001 in SET_S and 000 in RUN, decoded from the state register.
REQ-019 In RUN, a tick SHALL increment sec by 1 in BCD: units 9->0 carries to tens, and 59->00 carries into min.
REQ-020 A minute carry SHALL increment min with the same BCD rule, and 59->00 SHALL carry into hour.
REQ-021 Hours SHALL count 00..09->10..19->20..23->00; 23->00 SHALL NOT carry further.
REQ-022 All three fields SHALL update in the same CP edge as the tick, with zero added latency.
REQ-023 min_co, hour_co and day_co SHALL be registered and high only in the cycle after the wrapping edge, for exactly one cycle.
REQ-024 In any SET_x state, tick SHALL be ignored: time frozen, no carry pulses.
REQ-025 In SET_x, inc_btn SHALL increment only the selected field, with wrap (H 23->00, M/S 59->00), and SHALL NOT carry into other fields or pulse any *_co.
REQ-026 inc_btn SHALL be ignored in RUN.
REQ-027 If mode_btn and inc_btn are high in the same cycle, mode_btn SHALL take effect and inc_btn SHALL be discarded.
REQ-028 If tick and mode_btn are high in the same cycle in RUN, the tick SHALL be applied and the state SHALL move to SET_H on the same edge.
REQ-029 If mode_btn and tick are high in the same cycle in SET_S, the state SHALL return to RUN and that tick SHALL be ignored.
REQ-030 Every BCD digit SHALL remain a legal value at all times; no illegal digit is reachable from the legal parameter values.
REQ-031 Back-to-back ticks on consecutive cycles SHALL each produce one increment.

Reset
REQ-032 While CR=0, outputs SHALL asynchronously become: hour=PRESET_H, min=PRESET_M, sec=PRESET_S, state=RUN, set_sel=000, and min_co=hour_co=day_co=0.
REQ-033 CR asserted mid-operation, including in a SET_x state or in a cycle with a carry pulse pending, SHALL abort the operation immediately with no residual pulse after release.
REQ-034 After CR is released, the first rising CP edge with tick=1 SHALL be counted normally.

Verification
REQ-035 Reset, then 60 ticks -> sec 00..59 then 00, min=01, and exactly one min_co pulse.
REQ-036 Preload 23:59:58 via the SET mode, return to RUN, then 2 ticks -> 23:59:59, then 00:00:00, with min_co, hour_co and day_co each pulsing once, all in the same cycle.
REQ-037 SET_H at 23, one inc_btn -> hour=00 with no *_co; SET_M at 59, one inc -> 00 with hour unchanged; ticks during SET_x leave sec unchanged.
REQ-038 mode_btn and inc_btn together in SET_M -> state=SET_S, set_sel=001, min unchanged; tick and mode_btn together in RUN at sec=05 -> sec=06 and state=SET_H.
REQ-039 Drop CR asynchronously between CP edges while in SET_M at 12:34:56 -> outputs equal the PRESET values, state=RUN, with no carry pulses.
